// File: rtl/uart_tx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_if
// Producer-side bundle of the parametrised UART transmitter.
//   tx_valid  producer -> tx   a word is offered on tx_data
//   tx_data   producer -> tx   word to send (DATA_BITS wide)
//   tx_ready  tx -> producer   transmitter can take a word this cycle
//   tx_busy   tx -> producer   a frame is being shifted out
//   tx_done   tx -> producer   one-cycle pulse on the last clock of the last stop bit
//   tx_pin    tx -> line       serial output, idle high
// Modports: master = producer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
) ();
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 tx_busy;
   logic                 tx_done;
   logic                 tx_pin;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_busy, tx_done, tx_pin
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_busy, tx_done, tx_pin
   );
endinterface

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter with valid/ready input and a one-word holding
// buffer, so a word offered during a frame goes out immediately after it with
// no idle clocks on the line.
// Parameters:
//   CLK_DIV    clocks per serial bit (2..65535)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   uart_tx_frame_if slave: tx_valid/tx_data in, tx_ready/tx_busy/
//         tx_done/tx_pin out
// -----------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int CLK_DIV   = 434,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_frame_if.slave bus
);

   // Elaboration-time parameter checks
   if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
      $error("uart_tx_frame: CLK_DIV must be in 2..65535");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_tx_frame: DATA_BITS must be in 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // Parity bit that makes ones(data)+parity odd (PARITY=1) or even (PARITY=2)
   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      if (PARITY == 1) return ~(^d);
      else             return ^d;
   endfunction

   // Control state
   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_baud;
   logic [3:0]       r_bit;
   logic             r_pin;
   logic             r_buf_full;

   // Data registers (no reset needed; qualified by control state)
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_buf;
   logic                 r_par;

   logic [DATA_BITS-1:0] w_data;
   logic [DATA_BITS-1:0] w_load_data;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_busy;
   logic                 w_baud_last;
   logic                 w_frame_end;
   logic                 w_load;
   logic                 w_buf_wr;

   assign w_data      = bus.tx_data;
   assign w_ready     = ~r_buf_full;
   assign w_accept    = bus.tx_valid & w_ready;
   assign w_busy      = (r_state != S_IDLE);
   assign w_baud_last = (r_baud == BAUD_LAST);
   assign w_frame_end = (r_state == S_STOP) && w_baud_last && (r_bit == STOP_LAST);

   // A full buffer always wins at end of frame; ready is low then, so no
   // accept can collide with it.
   assign w_load_data = r_buf_full ? r_buf : w_data;
   assign w_load      = ((r_state == S_IDLE) && w_accept) ||
                        (w_frame_end && (r_buf_full || w_accept));
   // While a frame runs (and is not in its last clock) an accepted word parks
   // in the holding buffer.
   assign w_buf_wr    = w_accept && w_busy && !w_frame_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_pin      <= 1'b1;
         r_buf_full <= 1'b0;
      end else begin
         if (w_buf_wr)
            r_buf_full <= 1'b1;
         else if (w_frame_end && r_buf_full)
            r_buf_full <= 1'b0;

         if (w_load) begin
            r_state <= S_START;
            r_baud  <= '0;
            r_bit   <= '0;
            r_pin   <= 1'b0;
         end else if (w_busy) begin
            if (!w_baud_last) begin
               r_baud <= r_baud + 1'b1;
            end else begin
               r_baud <= '0;
               case (r_state)
                  S_START: begin
                     r_state <= S_DATA;
                     r_bit   <= '0;
                     r_pin   <= r_shift[0];
                  end
                  S_DATA: begin
                     if (r_bit == DATA_LAST) begin
                        r_bit <= '0;
                        if (PARITY != 0) begin
                           r_state <= S_PARITY;
                           r_pin   <= r_par;
                        end else begin
                           r_state <= S_STOP;
                           r_pin   <= 1'b1;
                        end
                     end else begin
                        r_bit <= r_bit + 1'b1;
                        // r_shift shifts in the data block; bit 1 is next out
                        r_pin <= r_shift[1];
                     end
                  end
                  S_PARITY: begin
                     r_state <= S_STOP;
                     r_bit   <= '0;
                     r_pin   <= 1'b1;
                  end
                  S_STOP: begin
                     if (r_bit == STOP_LAST) begin
                        r_state <= S_IDLE;
                        r_bit   <= '0;
                        r_pin   <= 1'b1;
                     end else begin
                        r_bit <= r_bit + 1'b1;
                     end
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_bit   <= '0;
                     r_pin   <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_buf_wr)
         r_buf <= w_data;

      if (w_load) begin
         r_shift <= w_load_data;
         r_par   <= parity_of(w_load_data);
      end else if (r_state == S_DATA && w_baud_last && r_bit != DATA_LAST) begin
         r_shift <= r_shift >> 1;
      end
   end

   assign bus.tx_ready = w_ready;
   assign bus.tx_busy  = w_busy;
   assign bus.tx_done  = w_frame_end;
   assign bus.tx_pin   = r_pin;

endmodule
